cxs_link_ctrl: RTL and testbench

CXS_LINK_CTRL -- requirements
Module: cxs_link_ctrl

---
 rtl/cxs_link_pkg.sv | 15 +
 rtl/cxs_credit_counter.sv | 31 +++
 rtl/cxs_link_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cxs_link_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cxs_link_pkg.sv
// Shared definitions for the CXS link controller: link state encoding and credit counter sizing.
package cxs_link_pkg;

  typedef enum logic [1:0] {
    LINK_STOP         = 2'b00,
    LINK_ACTIVATING   = 2'b01,
    LINK_DEACTIVATING = 2'b10,
    LINK_RUN          = 2'b11
  } link_state_e;

  function automatic int credit_width(input int max_credit);
    return $clog2(max_credit + 1);
  endfunction

endpackage

// File: rtl/cxs_credit_counter.sv
// Up/down credit counter, saturating at MAX_VAL and floored at zero; count is registered (1-cycle update).
// Simultaneous inc/dec cancel; overflow flags an inc with the count already at MAX_VAL and no dec.
module cxs_credit_counter #(
  parameter int MAX_VAL = 15,
  parameter int W       = 4,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W-1:0] MAX_W = W'(MAX_VAL);
  localparam logic [W-1:0] RST_W = W'(RST_VAL);

  assign overflow = inc && !dec && (count == MAX_W);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= RST_W;
    end else if (inc && !dec) begin
      if (count != MAX_W) count <= count + 1'b1;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/cxs_link_ctrl.sv
// CXS link controller: independent TX/RX activation FSMs, credit accounting, optional byte parity.
// Flits and credit pulses are registered (1-cycle latency); TX is throttled by held credits only.
module cxs_link_ctrl
  import cxs_link_pkg::*;
#(
  parameter int CXS_DATA_FLIT_WIDTH = 256,
  parameter int CXS_CNTL_WIDTH      = 14,
  parameter int CXS_MAX_CREDIT      = 15,
  parameter int CXS_CHECK_EN        = 0,
  localparam int DW = CXS_DATA_FLIT_WIDTH,
  localparam int NB = DW / 8,
  localparam int CW = credit_width(CXS_MAX_CREDIT)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cfg_enable,
  input  logic                      cfg_lp_req,
  input  logic                      tx_valid_in,
  input  logic [DW-1:0]             tx_data_in,
  input  logic [CXS_CNTL_WIDTH-1:0] tx_cntl_in,
  output logic                      tx_ready,
  output logic                      rx_valid_out,
  output logic [DW-1:0]             rx_data_out,
  output logic [CXS_CNTL_WIDTH-1:0] rx_cntl_out,
  input  logic                      rx_buf_release,
  output logic                      CXS_ACTIVE_REQ_TX,
  input  logic                      CXS_ACTIVE_ACK_TX,
  input  logic                      CXS_DEACT_HINT_TX,
  input  logic                      CXS_ACTIVE_REQ_RX,
  output logic                      CXS_ACTIVE_ACK_RX,
  output logic                      CXS_DEACT_HINT_RX,
  output logic [DW-1:0]             CXS_DATA_TX,
  output logic [CXS_CNTL_WIDTH-1:0] CXS_CNTL_TX,
  output logic                      CXS_VALID_TX,
  output logic                      CXS_CRDRTN_TX,
  input  logic                      CXS_CRDGNT_TX,
  output logic [NB-1:0]             CXS_DATA_CHK_TX,
  input  logic [DW-1:0]             CXS_DATA_RX,
  input  logic [CXS_CNTL_WIDTH-1:0] CXS_CNTL_RX,
  input  logic                      CXS_VALID_RX,
  input  logic                      CXS_CRDRTN_RX,
  output logic                      CXS_CRDGNT_RX,
  input  logic [NB-1:0]             CXS_DATA_CHK_RX,
  output logic [1:0]                tx_link_status,
  output logic [1:0]                rx_link_status,
  output logic [CW-1:0]             tx_credits,
  output logic [CW-1:0]             rx_credits_out,
  output logic [2:0]                err_status
);

  localparam logic [CW-1:0] MAX_W = CW'(CXS_MAX_CREDIT);

  link_state_e tx_state, tx_next, rx_state, rx_next;
  logic [CW-1:0] tx_cnt, rx_cnt, free_cnt;
  logic tx_send, tx_rtn, tx_ovf, rx_cnt_ovf, free_ovf, grant, par_bad;
  logic tx_ovf_err, rx_ovf_err, par_err;
  logic [DW-1:0] tx_dat_nxt;
  logic [NB-1:0] tx_par_nxt, rx_par;

  assign tx_ready = (tx_state == LINK_RUN) && (tx_cnt != '0);
  assign tx_send  = tx_ready && tx_valid_in;
  // Held credits are handed back one per cycle while winding the link down.
  assign tx_rtn   = (tx_state == LINK_DEACTIVATING) && (tx_cnt != '0);
  assign grant    = (rx_state == LINK_RUN) && (rx_cnt < MAX_W) && (free_cnt != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state <= LINK_STOP;
      rx_state <= LINK_STOP;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      LINK_STOP:         if (cfg_enable && !cfg_lp_req && !CXS_DEACT_HINT_TX) tx_next = LINK_ACTIVATING;
      LINK_ACTIVATING:   if (CXS_ACTIVE_ACK_TX) tx_next = LINK_RUN;
      LINK_RUN:          if (cfg_lp_req || CXS_DEACT_HINT_TX) tx_next = LINK_DEACTIVATING;
      LINK_DEACTIVATING: if ((tx_cnt == '0) && !CXS_ACTIVE_ACK_TX) tx_next = LINK_STOP;
      default:           tx_next = LINK_STOP;
    endcase
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      LINK_STOP:         if (CXS_ACTIVE_REQ_RX && cfg_enable) rx_next = LINK_ACTIVATING;
      LINK_ACTIVATING:   rx_next = LINK_RUN;
      LINK_RUN:          if (!CXS_ACTIVE_REQ_RX) rx_next = LINK_DEACTIVATING;
      LINK_DEACTIVATING: if (rx_cnt == '0) rx_next = LINK_STOP;
      default:           rx_next = LINK_STOP;
    endcase
  end

  cxs_credit_counter #(.MAX_VAL(CXS_MAX_CREDIT), .W(CW), .RST_VAL(0)) u_tx_cred (
    .clk(clk), .resetn(resetn), .inc(CXS_CRDGNT_TX), .dec(tx_send || tx_rtn),
    .count(tx_cnt), .overflow(tx_ovf)
  );

  cxs_credit_counter #(.MAX_VAL(CXS_MAX_CREDIT), .W(CW), .RST_VAL(0)) u_rx_cred (
    .clk(clk), .resetn(resetn), .inc(grant), .dec(CXS_VALID_RX || CXS_CRDRTN_RX),
    .count(rx_cnt), .overflow(rx_cnt_ovf)
  );

  // Buffers not yet promised to the remote side; a grant reserves one, a release returns one.
  cxs_credit_counter #(.MAX_VAL(CXS_MAX_CREDIT), .W(CW), .RST_VAL(CXS_MAX_CREDIT)) u_free_buf (
    .clk(clk), .resetn(resetn), .inc(rx_buf_release), .dec(grant),
    .count(free_cnt), .overflow(free_ovf)
  );

  assign tx_dat_nxt = tx_send ? tx_data_in : '0;

  always_comb begin
    tx_par_nxt = '0;
    rx_par     = '0;
    for (int i = 0; i < NB; i++) begin
      tx_par_nxt[i] = ~^tx_dat_nxt[8*i +: 8];
      rx_par[i]     = ~^CXS_DATA_RX[8*i +: 8];
    end
  end

  assign par_bad = (CXS_CHECK_EN != 0) && CXS_VALID_RX && (CXS_DATA_CHK_RX != rx_par);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      CXS_VALID_TX      <= 1'b0;
      CXS_DATA_TX       <= '0;
      CXS_CNTL_TX       <= '0;
      CXS_DATA_CHK_TX   <= '0;
      CXS_CRDRTN_TX     <= 1'b0;
      CXS_CRDGNT_RX     <= 1'b0;
      CXS_DEACT_HINT_RX <= 1'b0;
      rx_valid_out      <= 1'b0;
      rx_data_out       <= '0;
      rx_cntl_out       <= '0;
      tx_ovf_err        <= 1'b0;
      rx_ovf_err        <= 1'b0;
      par_err           <= 1'b0;
    end else begin
      CXS_VALID_TX      <= tx_send;
      CXS_DATA_TX       <= tx_dat_nxt;
      CXS_CNTL_TX       <= tx_send ? tx_cntl_in : '0;
      CXS_DATA_CHK_TX   <= (CXS_CHECK_EN != 0) ? tx_par_nxt : '0;
      CXS_CRDRTN_TX     <= tx_rtn;
      CXS_CRDGNT_RX     <= grant;
      CXS_DEACT_HINT_RX <= cfg_lp_req;
      rx_valid_out      <= CXS_VALID_RX;
      rx_data_out       <= CXS_VALID_RX ? CXS_DATA_RX : '0;
      rx_cntl_out       <= CXS_VALID_RX ? CXS_CNTL_RX : '0;
      tx_ovf_err        <= tx_ovf_err || tx_ovf;
      // A flit without a credit, or a release with every buffer already free, is an RX accounting overrun.
      rx_ovf_err        <= rx_ovf_err || (CXS_VALID_RX && (rx_cnt == '0)) || rx_cnt_ovf || free_ovf;
      par_err           <= par_err || par_bad;
    end
  end

  assign CXS_ACTIVE_REQ_TX = (tx_state == LINK_ACTIVATING) || (tx_state == LINK_RUN);
  assign CXS_ACTIVE_ACK_RX = (rx_state == LINK_RUN) || (rx_state == LINK_DEACTIVATING);
  assign tx_link_status    = tx_state;
  assign rx_link_status    = rx_state;
  assign tx_credits        = tx_cnt;
  assign rx_credits_out    = rx_cnt;
  assign err_status        = {par_err, rx_ovf_err, tx_ovf_err};

endmodule

// File: tb/tb_cxs_link_ctrl.sv
// Randomized bench for cxs_link_ctrl (MAX=4, parity on) against a credit-level reference model.
module tb_cxs_link_ctrl;

  localparam int DW   = 256;
  localparam int CNTL = 14;
  localparam int NB   = DW / 8;
  localparam int MAXC = 4;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            resetn;
  logic            cfg_enable, cfg_lp_req;
  logic            tx_valid_in;
  logic [DW-1:0]   tx_data_in;
  logic [CNTL-1:0] tx_cntl_in;
  logic            tx_ready;
  logic            rx_valid_out;
  logic [DW-1:0]   rx_data_out;
  logic [CNTL-1:0] rx_cntl_out;
  logic            rx_buf_release;
  logic            CXS_ACTIVE_REQ_TX, CXS_ACTIVE_ACK_TX, CXS_DEACT_HINT_TX;
  logic            CXS_ACTIVE_REQ_RX, CXS_ACTIVE_ACK_RX, CXS_DEACT_HINT_RX;
  logic [DW-1:0]   CXS_DATA_TX;
  logic [CNTL-1:0] CXS_CNTL_TX;
  logic            CXS_VALID_TX, CXS_CRDRTN_TX, CXS_CRDGNT_TX;
  logic [NB-1:0]   CXS_DATA_CHK_TX;
  logic [DW-1:0]   CXS_DATA_RX;
  logic [CNTL-1:0] CXS_CNTL_RX;
  logic            CXS_VALID_RX, CXS_CRDRTN_RX, CXS_CRDGNT_RX;
  logic [NB-1:0]   CXS_DATA_CHK_RX;
  logic [1:0]      tx_link_status, rx_link_status;
  logic [CW-1:0]   tx_credits, rx_credits_out;
  logic [2:0]      err_status;

  int n_vec = 0;
  int n_err = 0;
  int m_tx, m_out, m_free, gnt_seen, nrtn;
  logic [2:0] exp_err;

  always #5 clk = ~clk;

  cxs_link_ctrl #(
    .CXS_DATA_FLIT_WIDTH(DW), .CXS_CNTL_WIDTH(CNTL),
    .CXS_MAX_CREDIT(MAXC), .CXS_CHECK_EN(1)
  ) dut (
    .clk(clk), .resetn(resetn), .cfg_enable(cfg_enable), .cfg_lp_req(cfg_lp_req),
    .tx_valid_in(tx_valid_in), .tx_data_in(tx_data_in), .tx_cntl_in(tx_cntl_in), .tx_ready(tx_ready),
    .rx_valid_out(rx_valid_out), .rx_data_out(rx_data_out), .rx_cntl_out(rx_cntl_out),
    .rx_buf_release(rx_buf_release),
    .CXS_ACTIVE_REQ_TX(CXS_ACTIVE_REQ_TX), .CXS_ACTIVE_ACK_TX(CXS_ACTIVE_ACK_TX),
    .CXS_DEACT_HINT_TX(CXS_DEACT_HINT_TX), .CXS_ACTIVE_REQ_RX(CXS_ACTIVE_REQ_RX),
    .CXS_ACTIVE_ACK_RX(CXS_ACTIVE_ACK_RX), .CXS_DEACT_HINT_RX(CXS_DEACT_HINT_RX),
    .CXS_DATA_TX(CXS_DATA_TX), .CXS_CNTL_TX(CXS_CNTL_TX), .CXS_VALID_TX(CXS_VALID_TX),
    .CXS_CRDRTN_TX(CXS_CRDRTN_TX), .CXS_CRDGNT_TX(CXS_CRDGNT_TX), .CXS_DATA_CHK_TX(CXS_DATA_CHK_TX),
    .CXS_DATA_RX(CXS_DATA_RX), .CXS_CNTL_RX(CXS_CNTL_RX), .CXS_VALID_RX(CXS_VALID_RX),
    .CXS_CRDRTN_RX(CXS_CRDRTN_RX), .CXS_CRDGNT_RX(CXS_CRDGNT_RX), .CXS_DATA_CHK_RX(CXS_DATA_CHK_RX),
    .tx_link_status(tx_link_status), .rx_link_status(rx_link_status),
    .tx_credits(tx_credits), .rx_credits_out(rx_credits_out), .err_status(err_status)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] odd_par(input logic [DW-1:0] d);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i] = ~^d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_flit();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_tx_state", tx_link_status, 2'b00);
    check("rst_rx_state", rx_link_status, 2'b00);
    check("rst_tx_credits", tx_credits, 0);
    check("rst_rx_credits", rx_credits_out, 0);
    check("rst_err", err_status, 3'b000);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_req_ack", {CXS_ACTIVE_REQ_TX, CXS_ACTIVE_ACK_RX, CXS_DEACT_HINT_RX}, 3'b000);
    check("rst_pulses", {CXS_VALID_TX, CXS_CRDRTN_TX, CXS_CRDGNT_RX, rx_valid_out}, 4'b0000);
    check("rst_tx_data", CXS_DATA_TX, '0);
    check("rst_tx_chk", CXS_DATA_CHK_TX, '0);
    check("rst_rx_data", rx_data_out, '0);
    check("rst_cntl", {CXS_CNTL_TX, rx_cntl_out}, '0);
  endtask

  // One TX cycle with the link in RUN: a flit is taken iff a credit is held.
  task automatic tx_cycle(input bit v, input bit g);
    logic [DW-1:0] d, ed;
    logic [CNTL-1:0] c, ec;
    bit acc;
    d = rand_flit();
    c = CNTL'($urandom());
    acc = v && (m_tx != 0);
    tx_valid_in = v; tx_data_in = d; tx_cntl_in = c; CXS_CRDGNT_TX = g;
    check("tx_ready", tx_ready, m_tx != 0);
    tick();
    tx_valid_in = 1'b0; CXS_CRDGNT_TX = 1'b0;
    ed = acc ? d : '0;
    ec = acc ? c : '0;
    check("tx_valid", CXS_VALID_TX, acc);
    check("tx_data", CXS_DATA_TX, ed);
    check("tx_cntl", CXS_CNTL_TX, ec);
    check("tx_chk", CXS_DATA_CHK_TX, odd_par(ed));
    if (g && !acc) begin
      if (m_tx == MAXC) exp_err[0] = 1'b1;
      else m_tx++;
    end else if (acc && !g) begin
      m_tx--;
    end
    check("tx_credits", tx_credits, m_tx);
    check("tx_err", err_status, exp_err);
  endtask

  // One RX cycle with the link in RUN: buffers are split between free, outstanding credits and held flits.
  task automatic rx_cycle(input bit v, input bit rel, input bit bad);
    logic [DW-1:0] d;
    logic [CNTL-1:0] c;
    bit g;
    d = rand_flit();
    c = CNTL'($urandom());
    g = (m_out < MAXC) && (m_free > 0);
    CXS_VALID_RX = v; CXS_DATA_RX = d; CXS_CNTL_RX = c;
    CXS_DATA_CHK_RX = odd_par(d) ^ {{(NB-1){1'b0}}, bad};
    rx_buf_release = rel;
    tick();
    CXS_VALID_RX = 1'b0; rx_buf_release = 1'b0;
    if (CXS_CRDGNT_RX) gnt_seen++;
    check("rx_grant", CXS_CRDGNT_RX, g);
    check("rx_valid", rx_valid_out, v);
    check("rx_data", rx_data_out, v ? d : '0);
    check("rx_cntl", rx_cntl_out, v ? c : '0);
    if (v && m_out == 0) exp_err[1] = 1'b1;
    if (v && bad) exp_err[2] = 1'b1;
    if (g && !v) m_out++;
    else if (v && !g && m_out > 0) m_out--;
    m_free = m_free + int'(rel) - int'(g);
    check("rx_credits", rx_credits_out, m_out);
    check("rx_err", err_status, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    cfg_enable = 0; cfg_lp_req = 0;
    tx_valid_in = 0; tx_data_in = '0; tx_cntl_in = '0;
    rx_buf_release = 0;
    CXS_ACTIVE_ACK_TX = 0; CXS_DEACT_HINT_TX = 0; CXS_ACTIVE_REQ_RX = 0;
    CXS_CRDGNT_TX = 0; CXS_DATA_RX = '0; CXS_CNTL_RX = '0; CXS_VALID_RX = 0;
    CXS_CRDRTN_RX = 0; CXS_DATA_CHK_RX = '0;
    m_tx = 0; m_out = 0; m_free = MAXC; exp_err = 3'b000;
    repeat (3) tick();
    check_reset_state();
    resetn = 1'b1;
    tick();

    // TX bring-up: ack three cycles after the request, then four grants.
    cfg_enable = 1'b1;
    tick();
    check("tx_activating", tx_link_status, 2'b01);
    check("tx_req", CXS_ACTIVE_REQ_TX, 1'b1);
    repeat (2) tick();
    CXS_ACTIVE_ACK_TX = 1'b1;
    tick();
    check("tx_run", tx_link_status, 2'b11);
    repeat (MAXC) tx_cycle(1'b0, 1'b1);
    check("bringup_credits", tx_credits, MAXC);

    for (int i = 0; i < 200; i++)
      tx_cycle(1'($urandom_range(0, 1)), (m_tx < MAXC) && ($urandom_range(0, 2) == 0));

    // Drain all credits with no grants.
    for (int i = 0; i < 2*MAXC && m_tx < MAXC; i++) tx_cycle(1'b0, 1'b1);
    repeat (MAXC) tx_cycle(1'b1, 1'b0);
    check("drain_credits", tx_credits, 0);
    check("drain_ready", tx_ready, 1'b0);
    tx_cycle(1'b1, 1'b0);

    // Grant past the limit.
    repeat (MAXC) tx_cycle(1'b0, 1'b1);
    tx_cycle(1'b0, 1'b1);
    check("tx_ovf_flag", err_status[0], 1'b1);
    check("tx_ovf_sat", tx_credits, MAXC);

    // Local deactivation with three credits held.
    tx_cycle(1'b1, 1'b0);
    check("lp_credits", tx_credits, 3);
    cfg_lp_req = 1'b1;
    nrtn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (CXS_CRDRTN_TX) nrtn++;
    end
    check("rtn_count", nrtn, 3);
    check("tx_deact", tx_link_status, 2'b10);
    check("tx_deact_credits", tx_credits, 0);
    check("deact_hint_rx", CXS_DEACT_HINT_RX, 1'b1);
    CXS_ACTIVE_ACK_TX = 1'b0;
    tick();
    check("tx_stop", tx_link_status, 2'b00);
    check("tx_req_drop", CXS_ACTIVE_REQ_TX, 1'b0);

    // Remote activation of RX.
    CXS_ACTIVE_REQ_RX = 1'b1;
    tick();
    check("rx_activating", rx_link_status, 2'b01);
    tick();
    check("rx_run", rx_link_status, 2'b11);
    check("rx_ack", CXS_ACTIVE_ACK_RX, 1'b1);
    gnt_seen = 0;
    repeat (12) rx_cycle(1'b0, 1'b0, 1'b0);
    check("initial_grants", gnt_seen, MAXC);
    rx_cycle(1'b1, 1'b0, 1'b0);
    rx_cycle(1'b1, 1'b0, 1'b0);
    check("rx_after_2", rx_credits_out, MAXC - 2);
    gnt_seen = 0;
    rx_cycle(1'b0, 1'b1, 1'b0);
    rx_cycle(1'b0, 1'b1, 1'b0);
    repeat (8) rx_cycle(1'b0, 1'b0, 1'b0);
    check("release_grants", gnt_seen, 2);

    for (int i = 0; i < 300; i++)
      rx_cycle((m_out > 0) && ($urandom_range(0, 1) == 1),
               ((MAXC - m_out - m_free) > 0) && ($urandom_range(0, 2) == 0), 1'b0);

    repeat (12) rx_cycle(1'b0, (MAXC - m_out - m_free) > 0, 1'b0);
    check("rx_refilled", rx_credits_out, MAXC);

    // Corrupted check byte, then one flit beyond the outstanding credits.
    rx_cycle(1'b1, 1'b0, 1'b1);
    check("parity_err", err_status[2], 1'b1);
    repeat (MAXC - 1) rx_cycle(1'b1, 1'b0, 1'b0);
    rx_cycle(1'b1, 1'b0, 1'b0);
    check("rx_ovf_flag", err_status, 3'b111);

    // Asynchronous reset in the middle of a cycle while RX is running.
    CXS_VALID_RX = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    check_reset_state();
    nrtn = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (CXS_CRDRTN_TX) nrtn++;
    end
    check("rst_no_rtn", nrtn, 0);
    CXS_VALID_RX = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
